// File: rtl/random_scheduler.sv
// random_scheduler: round-robin sharing of one serial LFSR between requesters, with a refresh gap so no two granted words share LFSR bits
module random_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int REFRESH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        randIn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [15:0]        randOut,
  output logic               busy
);
  localparam int PW = $clog2(NUM_REQ);
  logic [4:0]    fresh_cnt;
  logic [PW-1:0] ptr, win, nxt, idx;
  logic          fresh, go;
  assign fresh = fresh_cnt == 5'(REFRESH);
  assign go = fresh && |req;
  assign nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  // winner is the first set request searching from ptr and wrapping; descending scan lets the nearest one win
  always_comb begin
    win = ptr;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) win = idx;
    end
  end
  // grant pulse and word capture on fresh edges; randIn is taken unregistered so the sampled bits stay disjoint
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= '0;
      randOut   <= '0;
      fresh_cnt <= '0;
      ptr       <= '0;
      busy      <= 1'b0;
    end else begin
      grant     <= go ? NUM_REQ'(1) << win : '0;
      randOut   <= go ? randIn : randOut;
      fresh_cnt <= go ? 5'd1 : fresh ? fresh_cnt : fresh_cnt + 5'd1;
      ptr       <= go ? nxt : ptr;
      busy      <= |req && !fresh;
    end
  end
endmodule

// File: tb/tb_random_scheduler.sv
// tb_random_scheduler: directed checks of grant timing, rotation, idle, dropped request and reset behaviour
module tb_random_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] lfsr = 16'h0001;
  logic [15:0] prev = '0;
  logic [3:0]  grant;
  logic [15:0] randOut;
  logic        busy;
  int          checks = 0;
  int          failures = 0;

  random_scheduler #(.NUM_REQ(4), .REFRESH(16)) dut (
    .clk(clk), .rst(rst), .randIn(lfsr), .req(req),
    .grant(grant), .randOut(randOut), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference LFSR shifting every clock; prev holds the value the DUT saw at the latest edge
  always @(posedge clk) begin
    prev <= lfsr;
    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, input int exp_n, input logic [3:0] exp_g);
    int n = 0;
    do begin
      tick();
      n++;
    end while (grant == 4'b0 && n < 80);
    chk({tag, "_gap"}, n, exp_n);
    chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
    chk({tag, "_word"}, 32'(randOut), 32'(prev));
  endtask

  initial begin
    logic [15:0] held;
    int bh, gc;
    req = 4'b0001;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_word", 32'(randOut), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("t1_busy%0d", i), 32'(busy), 1);
      chk($sformatf("t1_nogrant%0d", i), 32'(grant), 0);
    end
    tick();
    chk("t1_first_grant", 32'(grant), 32'h1);
    chk("t1_first_word", 32'(randOut), 32'(prev));
    chk("t1_busy_fresh", 32'(busy), 0);
    tick();
    chk("t1_pulse_width", 32'(grant), 0);
    wait_grant("t1_second", 15, 4'b0001);

    rst = 1'b0;
    #1;
    rst = 1'b1;
    req = 4'b1111;
    wait_grant("t2_g0", 17, 4'b0001);
    wait_grant("t2_g1", 16, 4'b0010);
    wait_grant("t2_g2", 16, 4'b0100);
    wait_grant("t2_g3", 16, 4'b1000);
    wait_grant("t2_g4", 16, 4'b0001);
    wait_grant("t2_g5", 16, 4'b0010);

    req = 4'b0011;
    wait_grant("t3_wrap", 16, 4'b0001);
    wait_grant("t3_ptr1", 16, 4'b0010);

    req = 4'b0000;
    bh = 0;
    gc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      bh += int'(busy);
      gc += int'(grant != 0);
    end
    chk("t4_busy_never", 32'(bh), 0);
    chk("t4_no_grant", 32'(gc), 0);
    req = 4'b0100;
    wait_grant("t4_idle_req", 1, 4'b0100);
    chk("t4_busy", 32'(busy), 0);

    held = randOut;
    req = 4'b1000;
    for (int i = 0; i < 9; i++) tick();
    chk("t5_busy_before_drop", 32'(busy), 1);
    req = 4'b0000;
    tick();
    chk("t5_busy_falls", 32'(busy), 0);
    gc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      gc += int'(grant != 0);
    end
    chk("t5_no_grant", 32'(gc), 0);
    chk("t5_word_held", 32'(randOut), 32'(held));

    req = 4'b0010;
    wait_grant("t6_pre", 1, 4'b0010);
    for (int i = 0; i < 7; i++) tick();
    chk("t6_busy_before", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_word", 32'(randOut), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    wait_grant("t6_after", 17, 4'b0010);
    rst = 1'b0;
    #1;
    chk("t6_grant_drop", 32'(grant), 0);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
